regfile_read_ctrl: RTL and testbench

- Sequences operand reads from the synchronous-read register file (1-cycle read latency) for the decode→execute path. Owns the register file write port.
- Tracks pending destination writes in a 32-entry scoreboard and stalls decode on RAW/WAW hazards.
- Bypasses a same-cycle write-back into the operand read.
- Sits between decode, the register file and execute.

---
 rtl/regfile_read_ctrl.sv | 167 ++++++++++++++++
 tb/tb_regfile_read_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_read_ctrl.sv
// ============================================================================
// regfile_read_ctrl : operand read sequencer with 32-entry scoreboard + bypass
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_read_ctrl #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              dec_valid,
   output logic              dec_ready,
   input  logic [REG_AW-1:0] dec_rs1,
   input  logic [REG_AW-1:0] dec_rs2,
   input  logic [REG_AW-1:0] dec_rd,
   input  logic              dec_rd_wen,
   output logic [REG_AW-1:0] rf_read_addr_1,
   output logic [REG_AW-1:0] rf_read_addr_2,
   input  logic [XLEN-1:0]   rf_read_data_1,
   input  logic [XLEN-1:0]   rf_read_data_2,
   output logic              rf_write_enable,
   output logic [REG_AW-1:0] rf_write_addr,
   output logic [XLEN-1:0]   rf_write_data,
   input  logic              wb_valid,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic [XLEN-1:0]   wb_data,
   output logic              ex_valid,
   input  logic              ex_ready,
   output logic [XLEN-1:0]   ex_rs1_data,
   output logic [XLEN-1:0]   ex_rs2_data,
   output logic [REG_AW-1:0] ex_rd,
   output logic              ex_rd_wen,
   output logic              sb_busy,
   output logic              wb_unexpected
);

   localparam int NUM_REGS = 2**REG_AW;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_OUT = 2'd2} state_t;

   state_t              state_q, state_d;
   logic [NUM_REGS-1:0] sb_q, sb_d;
   logic [REG_AW-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic                rd_wen_q, rd_wen_d;
   logic                byp1_q, byp1_d, byp2_q, byp2_d;
   logic [XLEN-1:0]     byp_data1_q, byp_data1_d, byp_data2_q, byp_data2_d;
   logic [XLEN-1:0]     ex_rs1_data_q, ex_rs1_data_d, ex_rs2_data_q, ex_rs2_data_d;
   logic                wb_unexp_q, wb_unexp_d;

   logic wb_clr, hit_rs1, hit_rs2, hit_rd, hazard, issue;

   assign wb_clr  = wb_valid && (wb_addr != '0);
   assign hit_rs1 = wb_clr && (wb_addr == dec_rs1);
   assign hit_rs2 = wb_clr && (wb_addr == dec_rs2);
   assign hit_rd  = wb_clr && (wb_addr == dec_rd);

   // A write-back landing this cycle resolves the hazard it would otherwise cause
   assign hazard = ((dec_rs1 != '0) && sb_q[dec_rs1] && !hit_rs1) ||
                   ((dec_rs2 != '0) && sb_q[dec_rs2] && !hit_rs2) ||
                   (dec_rd_wen && (dec_rd != '0) && sb_q[dec_rd] && !hit_rd);

   assign dec_ready = reset && (state_q == S_IDLE) && !hazard;
   assign issue     = dec_valid && dec_ready;

   assign rf_write_enable = reset && wb_clr;
   assign rf_write_addr   = wb_addr;
   assign rf_write_data   = wb_data;

   assign rf_read_addr_1 = (state_q == S_IDLE) ? dec_rs1 : rs1_q;
   assign rf_read_addr_2 = (state_q == S_IDLE) ? dec_rs2 : rs2_q;

   assign ex_valid      = reset && (state_q == S_OUT);
   assign ex_rs1_data   = ex_rs1_data_q;
   assign ex_rs2_data   = ex_rs2_data_q;
   assign ex_rd         = rd_q;
   assign ex_rd_wen     = rd_wen_q;
   assign sb_busy       = |sb_q;
   assign wb_unexpected = wb_unexp_q;

   always_comb begin
      state_d       = state_q;
      rs1_d         = rs1_q;
      rs2_d         = rs2_q;
      rd_d          = rd_q;
      rd_wen_d      = rd_wen_q;
      byp1_d        = byp1_q;
      byp2_d        = byp2_q;
      byp_data1_d   = byp_data1_q;
      byp_data2_d   = byp_data2_q;
      ex_rs1_data_d = ex_rs1_data_q;
      ex_rs2_data_d = ex_rs2_data_q;

      case (state_q)
         S_IDLE: begin
            if (issue) begin
               rs1_d    = dec_rs1;
               rs2_d    = dec_rs2;
               rd_d     = dec_rd;
               rd_wen_d = dec_rd_wen;
               // The RF read issued this cycle returns the pre-write value
               byp1_d   = hit_rs1;
               byp2_d   = hit_rs2;
               if (hit_rs1) byp_data1_d = wb_data;
               if (hit_rs2) byp_data2_d = wb_data;
               state_d  = S_READ;
            end
         end
         S_READ: begin
            ex_rs1_data_d = (rs1_q == '0) ? '0 : (byp1_q ? byp_data1_q : rf_read_data_1);
            ex_rs2_data_d = (rs2_q == '0) ? '0 : (byp2_q ? byp_data2_q : rf_read_data_2);
            state_d       = S_OUT;
         end
         S_OUT: begin
            if (ex_ready) begin
               byp1_d  = 1'b0;
               byp2_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      sb_d = sb_q;
      if (wb_clr) sb_d[wb_addr] = 1'b0;
      if (issue && dec_rd_wen && (dec_rd != '0)) sb_d[dec_rd] = 1'b1;
      sb_d[0] = 1'b0;

      wb_unexp_d = wb_unexp_q || (wb_clr && !sb_q[wb_addr]);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         sb_q          <= '0;
         rs1_q         <= '0;
         rs2_q         <= '0;
         rd_q          <= '0;
         rd_wen_q      <= 1'b0;
         byp1_q        <= 1'b0;
         byp2_q        <= 1'b0;
         byp_data1_q   <= '0;
         byp_data2_q   <= '0;
         ex_rs1_data_q <= '0;
         ex_rs2_data_q <= '0;
         wb_unexp_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         sb_q          <= sb_d;
         rs1_q         <= rs1_d;
         rs2_q         <= rs2_d;
         rd_q          <= rd_d;
         rd_wen_q      <= rd_wen_d;
         byp1_q        <= byp1_d;
         byp2_q        <= byp2_d;
         byp_data1_q   <= byp_data1_d;
         byp_data2_q   <= byp_data2_d;
         ex_rs1_data_q <= ex_rs1_data_d;
         ex_rs2_data_q <= ex_rs2_data_d;
         wb_unexp_q    <= wb_unexp_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_regfile_read_ctrl.sv
// ============================================================================
// tb_regfile_read_ctrl : directed self-checking bench with a sync-read RF model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_regfile_read_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        dec_valid;
   logic        dec_ready;
   logic [4:0]  dec_rs1, dec_rs2, dec_rd;
   logic        dec_rd_wen;
   logic [4:0]  rf_read_addr_1, rf_read_addr_2;
   logic [31:0] rf_read_data_1, rf_read_data_2;
   logic        rf_write_enable;
   logic [4:0]  rf_write_addr;
   logic [31:0] rf_write_data;
   logic        wb_valid;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_rs1_data, ex_rs2_data;
   logic [4:0]  ex_rd;
   logic        ex_rd_wen;
   logic        sb_busy;
   logic        wb_unexpected;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] mem [32];

   always #5 clk = ~clk;

   regfile_read_ctrl #(.XLEN(32), .REG_AW(5)) dut (
      .clk(clk), .reset(reset),
      .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_rd_wen(dec_rd_wen),
      .rf_read_addr_1(rf_read_addr_1), .rf_read_addr_2(rf_read_addr_2),
      .rf_read_data_1(rf_read_data_1), .rf_read_data_2(rf_read_data_2),
      .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
      .rf_write_data(rf_write_data),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
      .ex_rd(ex_rd), .ex_rd_wen(ex_rd_wen),
      .sb_busy(sb_busy), .wb_unexpected(wb_unexpected)
   );

   // Synchronous-read register file: read-before-write on the same address
   always @(posedge clk) begin
      if (rf_write_enable) mem[rf_write_addr] <= rf_write_data;
      rf_read_data_1 <= mem[rf_read_addr_1];
      rf_read_data_2 <= mem[rf_read_addr_2];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic wen);
      dec_valid  = 1'b1;
      dec_rs1    = rs1;
      dec_rs2    = rs2;
      dec_rd     = rd;
      dec_rd_wen = wen;
   endtask

   task automatic wb(input logic v, input logic [4:0] a, input logic [31:0] d);
      wb_valid = v;
      wb_addr  = a;
      wb_data  = d;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      mem[0] = 32'hDEAD_BEEF;
      reset = 1'b0; dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
      dec_rd_wen = 1'b0; ex_ready = 1'b0;
      wb(1'b1, 5'd3, 32'h11);
      #1;
      check("rst_wen_gated", {31'b0, rf_write_enable}, 32'h0);
      check("rst_dec_ready", {31'b0, dec_ready}, 32'h0);
      tick(); tick();
      check("rst_ex_valid", {31'b0, ex_valid}, 32'h0);
      check("rst_sb_busy", {31'b0, sb_busy}, 32'h0);
      check("rst_unexp", {31'b0, wb_unexpected}, 32'h0);
      check("rst_ex_rd", {27'b0, ex_rd}, 32'h0);
      check("rst_ex_rs1", ex_rs1_data, 32'h0);
      reset = 1'b1;

      // Preload x3/x4 through the write port; these are unexpected write-backs
      wb(1'b1, 5'd3, 32'h11); #1;
      check("wen_pass", {31'b0, rf_write_enable}, 32'h1);
      check("waddr_pass", {27'b0, rf_write_addr}, 32'd3);
      tick();
      check("unexp_set", {31'b0, wb_unexpected}, 32'h1);
      wb(1'b1, 5'd4, 32'h22); tick();
      wb(1'b0, 5'd0, 32'h0);
      reset = 1'b0; tick(); reset = 1'b1;
      check("unexp_clr_rst", {31'b0, wb_unexpected}, 32'h0);

      // Basic issue: rs1=3 rs2=4 rd=5
      present(5'd3, 5'd4, 5'd5, 1'b1); #1;
      check("t1_ready", {31'b0, dec_ready}, 32'h1);
      tick(); dec_valid = 1'b0;
      check("t1_ex_valid_T1", {31'b0, ex_valid}, 32'h0);
      check("t1_sb_busy", {31'b0, sb_busy}, 32'h1);
      tick();
      check("t1_ex_valid_T2", {31'b0, ex_valid}, 32'h1);
      check("t1_rs1", ex_rs1_data, 32'h11);
      check("t1_rs2", ex_rs2_data, 32'h22);
      check("t1_rd", {27'b0, ex_rd}, 32'd5);
      check("t1_rd_wen", {31'b0, ex_rd_wen}, 32'h1);
      ex_ready = 1'b1; tick(); ex_ready = 1'b0;

      // RAW on x5, resolved by a same-cycle write-back that must be bypassed
      present(5'd5, 5'd0, 5'd6, 1'b0); #1;
      check("raw_stall0", {31'b0, dec_ready}, 32'h0);
      tick();
      check("raw_stall1", {31'b0, dec_ready}, 32'h0);
      wb(1'b1, 5'd5, 32'hABCD); #1;
      check("raw_ready_on_wb", {31'b0, dec_ready}, 32'h1);
      tick(); dec_valid = 1'b0; wb(1'b0, 5'd0, 32'h0);
      check("raw_sb_clear", {31'b0, sb_busy}, 32'h0);
      check("raw_no_unexp", {31'b0, wb_unexpected}, 32'h0);
      tick();
      check("raw_ex_valid", {31'b0, ex_valid}, 32'h1);
      check("raw_bypass", ex_rs1_data, 32'hABCD);
      check("raw_rs2_zero", ex_rs2_data, 32'h0);
      ex_ready = 1'b1; tick(); ex_ready = 1'b0;

      // WAW on x7: set wins over same-cycle clear
      present(5'd0, 5'd0, 5'd7, 1'b1); tick(); dec_valid = 1'b0; tick();
      ex_ready = 1'b1; tick(); ex_ready = 1'b0;
      present(5'd0, 5'd0, 5'd7, 1'b1); #1;
      check("waw_stall", {31'b0, dec_ready}, 32'h0);
      wb(1'b1, 5'd7, 32'h77); #1;
      check("waw_ready_on_wb", {31'b0, dec_ready}, 32'h1);
      tick(); dec_valid = 1'b0; wb(1'b0, 5'd0, 32'h0);
      check("waw_set_wins", {31'b0, sb_busy}, 32'h1);
      tick();
      ex_ready = 1'b1; tick(); ex_ready = 1'b0;
      wb(1'b1, 5'd7, 32'h78); tick(); wb(1'b0, 5'd0, 32'h0);
      check("waw_cleared", {31'b0, sb_busy}, 32'h0);
      check("waw_no_unexp", {31'b0, wb_unexpected}, 32'h0);

      // x0: writes suppressed, reads forced to zero, never tracked
      wb(1'b1, 5'd0, 32'hFFFF); #1;
      check("x0_wen", {31'b0, rf_write_enable}, 32'h0);
      tick(); wb(1'b0, 5'd0, 32'h0);
      check("x0_no_unexp", {31'b0, wb_unexpected}, 32'h0);
      present(5'd0, 5'd3, 5'd0, 1'b1); #1;
      check("x0_ready", {31'b0, dec_ready}, 32'h1);
      tick(); dec_valid = 1'b0;
      check("x0_sb", {31'b0, sb_busy}, 32'h0);
      tick();
      check("x0_rs1_forced", ex_rs1_data, 32'h0);
      check("x0_rs2", ex_rs2_data, 32'h11);
      ex_ready = 1'b1; tick(); ex_ready = 1'b0;

      // Backpressure then mid-operation reset
      present(5'd3, 5'd4, 5'd8, 1'b1); tick();
      present(5'd1, 5'd2, 5'd0, 1'b0); tick();
      for (int i = 0; i < 5; i++) begin
         check("bp_ex_valid", {31'b0, ex_valid}, 32'h1);
         check("bp_rs1", ex_rs1_data, 32'h11);
         check("bp_dec_ready", {31'b0, dec_ready}, 32'h0);
         tick();
      end
      dec_valid = 1'b0;
      reset = 1'b0; #1;
      check("rst_mid_ex_valid", {31'b0, ex_valid}, 32'h0);
      tick(); reset = 1'b1; #1;
      check("post_rst_ex_valid", {31'b0, ex_valid}, 32'h0);
      check("post_rst_sb", {31'b0, sb_busy}, 32'h0);
      check("post_rst_idle", {31'b0, dec_ready}, 32'h1);
      check("post_rst_ex_rd", {27'b0, ex_rd}, 32'h0);

      // Unexpected write-back to x9 is performed and flagged stickily
      wb(1'b1, 5'd9, 32'h99); #1;
      check("unexp_wen", {31'b0, rf_write_enable}, 32'h1);
      tick(); wb(1'b0, 5'd0, 32'h0);
      check("unexp_flag", {31'b0, wb_unexpected}, 32'h1);
      present(5'd9, 5'd0, 5'd0, 1'b0); tick(); dec_valid = 1'b0; tick();
      check("unexp_written", ex_rs1_data, 32'h99);
      check("unexp_sticky", {31'b0, wb_unexpected}, 32'h1);
      ex_ready = 1'b1; tick(); ex_ready = 1'b0;
      reset = 1'b0; tick(); reset = 1'b1; #1;
      check("unexp_rst_clear", {31'b0, wb_unexpected}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
